mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Parametrised N-master, byte-wide memory-bus arbiter and address decoder.
- Sits between bus masters (CPU instruction/data ports, host debug interface) and the two slaves: internal synchronous RAM and the byte I/O block.
- Generalises the fixed two-way debug/CPU mux with round-robin arbitration, lock (burst) support, debug preemption and a tracked 1-cycle read-return path.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
DBG_MASTER, 0, index of the master that owns the bus while dbg_active is high
ADDR_WIDTH, 32, master address width
RAM_ADDR_WIDTH, 17, RAM address width; bits [RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11 select I/O
IO_SEL_WIDTH, 3, I/O register select width (low address bits)

Ports:
clk_in  input  1  system clock, all logic on rising edge
rst_n_in  input  1  synchronous active-low reset
dbg_active  input  1  debug break; only DBG_MASTER may be granted
m_req  input  NUM_MASTERS  per-master request, held until granted
m_lock  input  NUM_MASTERS  per-master request to keep grant on next cycle
m_wr  input  NUM_MASTERS  1=write, 0=read
m_a  input  NUM_MASTERS*ADDR_WIDTH  flattened addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
m_wdata  input  NUM_MASTERS*8  flattened write data
m_gnt  output  NUM_MASTERS  one-hot; request accepted this cycle
m_rvalid  output  NUM_MASTERS  one-hot; m_rdata valid for that master
m_rdata  output  8  read-return data
ram_en  output  1  RAM enable
ram_wr  output  1  RAM write
ram_a  output  RAM_ADDR_WIDTH  RAM address
ram_din  output  8  RAM write data
ram_dout  input  8  RAM read data, valid one cycle after ram_en
io_en  output  1  I/O enable
io_wr  output  1  I/O write
io_sel  output  IO_SEL_WIDTH  I/O register select
io_din  output  8  I/O write data
io_dout  input  8  I/O read data, valid one cycle after io_en
bus_idle  output  1  no grant this cycle and no read outstanding

Behaviour:
- Reset (rst_n_in low at posedge): rr_ptr=NUM_MASTERS-1 (so master 0 has first priority); lock owner cleared; read-return regs cleared.
- Every output derived from registered state is 0 during and after reset: m_rvalid, m_gnt, ram_en, io_en, ram_wr, io_wr. bus_idle=1.
- A read in flight at reset is dropped; its m_rvalid never asserts.
- Arbitration is combinational within a cycle, with registered state. Priority:
  - dbg_active=1: grant DBG_MASTER iff it requests; all other masters stalled (m_gnt=0), including a lock owner.
  - Otherwise, lock owner valid and still requesting: grant lock owner.
  - Otherwise: round-robin from rr_ptr+1 (mod NUM_MASTERS) upward; first requester wins.
- On grant to master g: rr_ptr<=g. Lock owner<=g if m_lock[g], else cleared. Lock is also cleared when the owner deasserts m_req, or when a dbg_active preemption occurs.
- Decode of the granted address a: io = (a[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11).
  - io=1: io_en=1, io_sel=a[IO_SEL_WIDTH-1:0].
  - io=0: ram_en=1, ram_a=a[RAM_ADDR_WIDTH-1:0].
  - wr and data are forwarded to both slaves; the enables are exclusive.
- No grant: enables and writes are 0; address and data outputs are don't-care but held at 0.
- Read return latency is exactly 1 cycle. A granted read in cycle t registers {master g, io flag}. In cycle t+1, m_rvalid[g]=1 and m_rdata = io_flag ? io_dout : ram_dout.
- Writes never produce m_rvalid.
- Back-to-back reads from different masters every cycle are supported; each receives its own m_rvalid one cycle later.
- m_rdata is 0 when no m_rvalid is set.
- Simultaneous requests from all masters with no lock: each master is granted once per NUM_MASTERS cycles.
- dbg_active rising mid-lock: preempts on that same cycle. A read already granted in the previous cycle still returns.

Optional Feature:
- Macro ARB_PERF_EN.
- When defined: adds output perf_gnt_cnt (NUM_MASTERS*32, flattened) with one 32-bit counter per master.
  - Increments on every cycle that master is granted; wraps at 2^32.
  - Cleared by reset.
  - Adds output perf_stall_cnt (32): counts cycles where m_req!=0 and m_gnt==0.
- When undefined: neither port nor counters exist; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n_in low 2 cycles with all m_req=1 -> m_gnt=0, ram_en=0, io_en=0, m_rvalid=0, bus_idle=1; first cycle after release grants master 0.
- Round-robin: NUM_MASTERS=3, all request reads at 0x100 continuously -> grants 0,1,2,0,1,2; m_rvalid one-hot follows one cycle later; m_rdata equals ram_dout.
- I/O decode: master 1 writes 0x41 to 0x30004 -> io_en=1, io_wr=1, io_sel=4, io_din=0x41, ram_en=0. Master 1 then reads 0x30000 with io_dout=0x5A -> next cycle m_rvalid[1]=1, m_rdata=0x5A.
- Lock: master 1 requests with m_lock=1 for 4 cycles while master 0 requests -> master 1 granted 4 consecutive cycles; after m_lock drops, master 0 granted next.
- Debug preemption: master 1 locked; dbg_active rises with master 0 requesting -> same cycle m_gnt=01. While dbg_active=1 and master 0 idle, m_gnt=0.
- Reset mid-read: grant a read, pull rst_n_in low next cycle -> m_rvalid stays 0. With ARB_PERF_EN defined, counters read 0 after reset and perf_gnt_cnt[0] increments by exactly 1 per master-0 grant.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - N-master byte-bus arbiter, RAM/IO decoder and 1-cycle read-return tracker.
// Optional per-master grant / stall counters are built when ARB_PERF_EN is defined.
module mem_bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int DBG_MASTER     = 0,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int IO_SEL_WIDTH   = 3
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            dbg_active,
    input  logic [NUM_MASTERS-1:0]          m_req,
    input  logic [NUM_MASTERS-1:0]          m_lock,
    input  logic [NUM_MASTERS-1:0]          m_wr,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_a,
    input  logic [NUM_MASTERS*8-1:0]        m_wdata,
    output logic [NUM_MASTERS-1:0]          m_gnt,
    output logic [NUM_MASTERS-1:0]          m_rvalid,
    output logic [7:0]                      m_rdata,
    output logic                            ram_en,
    output logic                            ram_wr,
    output logic [RAM_ADDR_WIDTH-1:0]       ram_a,
    output logic [7:0]                      ram_din,
    input  logic [7:0]                      ram_dout,
    output logic                            io_en,
    output logic                            io_wr,
    output logic [IO_SEL_WIDTH-1:0]         io_sel,
    output logic [7:0]                      io_din,
    input  logic [7:0]                      io_dout,
    output logic                            bus_idle
`ifdef ARB_PERF_EN
    ,
    output logic [NUM_MASTERS*32-1:0]       perf_gnt_cnt,
    output logic [31:0]                     perf_stall_cnt
`endif
);

    localparam int IDXW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic            lock_vld_q, lock_vld_d;
    logic [IDXW-1:0] lock_own_q, lock_own_d;
    logic            rd_vld_q, rd_vld_d;
    logic [IDXW-1:0] rd_mst_q, rd_mst_d;
    logic            rd_io_q, rd_io_d;

    logic            gnt_vld;
    logic [IDXW-1:0] gnt_idx;
    int              rr_idx;

    logic [ADDR_WIDTH-1:0] sel_a;
    logic                  sel_wr;
    logic                  sel_lock;
    logic [7:0]            sel_wd;
    logic                  sel_io;
    logic                  rd_live;
    logic                  unused_addr_bits;

    // Grants are suppressed while reset is asserted so nothing reaches the slaves.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr_idx  = 0;
        if (rst_n_in) begin
            if (dbg_active) begin
                if (m_req[DBG_MASTER]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = IDXW'(DBG_MASTER);
                end
            end else if (lock_vld_q && m_req[lock_own_q]) begin
                gnt_vld = 1'b1;
                gnt_idx = lock_own_q;
            end else begin
                for (int k = 1; k <= NUM_MASTERS; k++) begin
                    rr_idx = (int'(rr_ptr_q) + k) % NUM_MASTERS;
                    if (!gnt_vld && m_req[rr_idx]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = IDXW'(rr_idx);
                    end
                end
            end
        end
    end

    always_comb begin
        sel_a    = '0;
        sel_wr   = 1'b0;
        sel_lock = 1'b0;
        sel_wd   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_gnt[i] = gnt_vld && (gnt_idx == IDXW'(i));
            if (m_gnt[i]) begin
                sel_a    = m_a[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wr   = m_wr[i];
                sel_lock = m_lock[i];
                sel_wd   = m_wdata[i*8 +: 8];
            end
        end
    end

    assign sel_io           = (sel_a[RAM_ADDR_WIDTH -: 2] == 2'b11);
    assign unused_addr_bits = ^sel_a[ADDR_WIDTH-1:RAM_ADDR_WIDTH+1];

    assign ram_en  = gnt_vld && !sel_io;
    assign io_en   = gnt_vld && sel_io;
    assign ram_wr  = sel_wr;
    assign io_wr   = sel_wr;
    assign ram_a   = ram_en ? sel_a[RAM_ADDR_WIDTH-1:0] : '0;
    assign io_sel  = io_en ? sel_a[IO_SEL_WIDTH-1:0] : '0;
    assign ram_din = sel_wd;
    assign io_din  = sel_wd;

    // A debug break always drops any lock; an idle owner loses it too.
    always_comb begin
        rr_ptr_d   = gnt_vld ? gnt_idx : rr_ptr_q;
        lock_vld_d = gnt_vld && !dbg_active && sel_lock;
        lock_own_d = gnt_idx;
        rd_vld_d   = gnt_vld && !sel_wr;
        rd_mst_d   = gnt_idx;
        rd_io_d    = sel_io;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            rr_ptr_q   <= IDXW'(NUM_MASTERS - 1);
            lock_vld_q <= 1'b0;
            lock_own_q <= '0;
            rd_vld_q   <= 1'b0;
            rd_mst_q   <= '0;
            rd_io_q    <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
            rd_vld_q   <= rd_vld_d;
            rd_mst_q   <= rd_mst_d;
            rd_io_q    <= rd_io_d;
        end
    end

    // Gating with reset drops a read that was in flight when reset arrived.
    assign rd_live = rd_vld_q && rst_n_in;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_rvalid[i] = rd_live && (rd_mst_q == IDXW'(i));
        end
    end

    assign m_rdata  = rd_live ? (rd_io_q ? io_dout : ram_dout) : 8'h00;
    assign bus_idle = !gnt_vld && !rd_live;

`ifdef ARB_PERF_EN
    logic [NUM_MASTERS*32-1:0] perf_gnt_q;
    logic [31:0]               perf_stall_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            perf_gnt_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (m_gnt[i]) begin
                    perf_gnt_q[i*32 +: 32] <= perf_gnt_q[i*32 +: 32] + 32'd1;
                end
            end
            if ((|m_req) && !(|m_gnt)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_gnt_cnt   = perf_gnt_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
